// File: rtl/present_pkg.sv
// Shared PRESENT definitions: key sizes, default round count, the key-schedule
// state type and the 4-bit S-box.
package present_pkg;

  localparam int KEY_SIZE_80        = 80;
  localparam int KEY_SIZE_128       = 128;
  localparam int RK_WIDTH_DEFAULT   = 64;
  localparam int NUM_ROUNDS_DEFAULT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } key_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_sched_if.sv
// Key-load handshake and round-key read port of the PRESENT key scheduler.
// The master side is the key loader / round datapath, the slave is the scheduler.
interface present_key_sched_if
  import present_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_80,
  parameter int RK_WIDTH = RK_WIDTH_DEFAULT,
  parameter int IDX_W    = $clog2(NUM_ROUNDS_DEFAULT + 1)
);

  logic                key_valid;
  logic                key_ready;
  logic [KEY_SIZE-1:0] key_in;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    rd_idx;
  logic [RK_WIDTH-1:0] rd_key;
  logic                rd_err;

  modport master (
    output key_valid, key_in, rd_idx,
    input  key_ready, busy, done, rd_key, rd_err
  );

  modport slave (
    input  key_valid, key_in, rd_idx,
    output key_ready, busy, done, rd_key, rd_err
  );

endinterface

// File: rtl/present_key_sched_key_update.sv
// One combinational PRESENT key-register update (80- or 128-bit variant),
// kept separate so an on-the-fly scheduler can reuse it.
module key_update
  import present_pkg::*;
#(
  parameter int KEY_SIZE = KEY_SIZE_80
) (
  input  logic [KEY_SIZE-1:0] key,
  input  logic [4:0]          round_idx,
  output logic [KEY_SIZE-1:0] key_next
);

  logic [KEY_SIZE-1:0] rot;

  assign rot = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};

  generate
    if (KEY_SIZE == KEY_SIZE_80) begin : g_key80
      always_comb begin
        key_next        = rot;
        key_next[79:76] = sbox(rot[79:76]);
        key_next[19:15] = rot[19:15] ^ round_idx;
      end
    end else if (KEY_SIZE == KEY_SIZE_128) begin : g_key128
      always_comb begin
        key_next          = rot;
        key_next[127:124] = sbox(rot[127:124]);
        key_next[123:120] = sbox(rot[123:120]);
        key_next[66:62]   = rot[66:62] ^ round_idx;
      end
    end else begin : g_bad_key_size
      $error("key_update: KEY_SIZE must be 80 or 128");
      assign key_next = rot;
    end
  endgenerate

endmodule

// File: rtl/present_key_sched.sv
// Sequential PRESENT key schedule: expands a master key into NUM_ROUNDS+1
// round keys, one per clock, and serves them through a registered read port.
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEY_SIZE   = KEY_SIZE_80,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int RK_WIDTH   = RK_WIDTH_DEFAULT,
  parameter int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
  input logic               clk,
  input logic               rst_n,
  present_key_sched_if.slave bus
);

  localparam int         SEL_W      = $clog2(NUM_ROUNDS + 1);
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  key_state_t          state;
  logic [4:0]          round_cnt;
  logic                last_wr;
  logic [KEY_SIZE-1:0] key_reg;
  logic [KEY_SIZE-1:0] key_next;
  logic [RK_WIDTH-1:0] rk_file [0:NUM_ROUNDS];
  logic                load;
  logic                rd_ok;
  logic [SEL_W-1:0]    rd_sel;
  logic [SEL_W-1:0]    wr_sel;

  key_update #(.KEY_SIZE(KEY_SIZE)) u_key_update (
    .key       (key_reg),
    .round_idx (round_cnt),
    .key_next  (key_next)
  );

  assign bus.key_ready = (state != EXPAND);
  assign bus.busy      = (state == EXPAND);
  assign bus.done      = (state == READY);
  assign load          = bus.key_valid && bus.key_ready;
  assign wr_sel        = SEL_W'(round_cnt);
  assign rd_sel        = SEL_W'(bus.rd_idx);
  assign rd_ok         = (state == READY) && (int'(bus.rd_idx) <= NUM_ROUNDS);

  // last_wr adds the settle cycle after the final entry so done rises
  // NUM_ROUNDS+1 cycles after the handshake; the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_cnt <= '0;
      last_wr   <= 1'b0;
      key_reg   <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (bus.key_valid) begin
            key_reg   <= bus.key_in;
            round_cnt <= 5'd1;
            last_wr   <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (last_wr) begin
            last_wr <= 1'b0;
            state   <= READY;
          end else begin
            key_reg <= key_next;
            last_wr <= (round_cnt == LAST_ROUND);
            if (round_cnt != LAST_ROUND) begin
              round_cnt <= round_cnt + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The key file itself is not reset; done=0 keeps stale entries hidden.
  always_ff @(posedge clk) begin
    if (load) begin
      rk_file[0] <= bus.key_in[KEY_SIZE-1 -: RK_WIDTH];
    end else if ((state == EXPAND) && !last_wr) begin
      rk_file[wr_sel] <= key_next[KEY_SIZE-1 -: RK_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_key <= '0;
      bus.rd_err <= 1'b1;
    end else if (rd_ok) begin
      bus.rd_key <= rk_file[rd_sel];
      bus.rd_err <= 1'b0;
    end else begin
      bus.rd_err <= 1'b1;
    end
  end

endmodule
